lif_neuron_array: RTL



---
 rtl/lif_pkg.sv | 28 ++
 rtl/lif_neuron_array_if.sv | 27 ++
 rtl/lif_update_unit.sv | 49 ++++
 rtl/lif_neuron_array.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and sizing helpers for the time-multiplexed LIF neuron array.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    OUT    = 2'd2
  } state_e;

  localparam int DEF_N          = 8;
  localparam int DEF_W          = 8;
  localparam int DEF_IN_WEIGHT  = 8;
  localparam int DEF_LEAK_SHIFT = 2;
  localparam int DEF_REFRAC     = 2;
  localparam int DEF_RESET_VAL  = 0;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Counter must hold REFRAC itself, and never collapse to zero bits.
  function automatic int refrac_width(input int r);
    return (r < 1) ? 1 : $clog2(r + 1);
  endfunction

  localparam int DEF_RW = refrac_width(DEF_REFRAC);

endpackage

// File: rtl/lif_neuron_array_if.sv
// Input-timestep and output-spike-vector handshakes of the LIF neuron array.
interface lif_neuron_array_if
  import lif_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_spikes;
  logic [W-1:0] thresh;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_spikes;

  modport master (
    output in_valid, in_spikes, thresh, out_ready,
    input  in_ready, out_valid, out_spikes
  );

  modport slave (
    input  in_valid, in_spikes, thresh, out_ready,
    output in_ready, out_valid, out_spikes
  );

endinterface

// File: rtl/lif_update_unit.sv
// Combinational single-neuron LIF step: leak, integrate with saturation,
// threshold compare and refractory handling.
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int IN_WEIGHT  = DEF_IN_WEIGHT,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRAC     = DEF_REFRAC,
  parameter int RESET_VAL  = DEF_RESET_VAL,
  parameter int RW         = refrac_width(REFRAC)
) (
  input  logic [W-1:0]  p,
  input  logic [RW-1:0] r,
  input  logic          in_bit,
  input  logic [W-1:0]  thresh,
  output logic [W-1:0]  p_next,
  output logic [RW-1:0] r_next,
  output logic          spike
);

  localparam logic [W:0]    WEIGHT_X = (W+1)'(IN_WEIGHT);
  localparam logic [W-1:0]  RESET_P  = W'(RESET_VAL);
  localparam logic [RW-1:0] REFRAC_R = RW'(REFRAC);
  localparam logic [W-1:0]  P_MAX    = '1;

  logic [W-1:0] leaked;
  logic [W:0]   sum;
  logic [W-1:0] sat;

  // The extra sum bit catches overflow so the potential clamps instead of wrapping.
  always_comb begin
    leaked = p - (p >> LEAK_SHIFT);
    sum    = {1'b0, leaked} + (in_bit ? WEIGHT_X : '0);
    sat    = sum[W] ? P_MAX : sum[W-1:0];
    p_next = sat;
    r_next = r;
    spike  = 1'b0;
    if (r != '0) begin
      p_next = RESET_P;
      r_next = r - 1'b1;
    end else if (sat >= thresh) begin
      spike  = 1'b1;
      p_next = RESET_P;
      r_next = REFRAC_R;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Array of N leaky integrate-and-fire neurons sharing one update datapath,
// swept one neuron per cycle for each accepted input timestep.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int W          = DEF_W,
  parameter int IN_WEIGHT  = DEF_IN_WEIGHT,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRAC     = DEF_REFRAC,
  parameter int RESET_VAL  = DEF_RESET_VAL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  lif_neuron_array_if.slave  bus,
  output logic               busy
);

  localparam int IW = idx_width(N);
  localparam int RW = refrac_width(REFRAC);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  pot_q [N];
  logic [RW-1:0] ref_q [N];
  logic [N-1:0]  spk_in_q;
  logic [N-1:0]  out_spk_q;
  logic [W-1:0]  thr_q;

  logic          accept;
  logic          step;
  logic [W-1:0]  p_cur, p_next;
  logic [RW-1:0] r_cur, r_next;
  logic          in_bit;
  logic          spike;

  // Soft clear overrides every transition, so in_ready drops while it is held.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    accept        = 1'b0;
    step          = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = !clr;
        accept       = bus.in_valid && !clr;
        if (accept) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        busy = 1'b1;
        step = !clr;
        if (idx_q == IW'(N - 1)) begin
          state_d = OUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      OUT: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
      idx_d   = '0;
    end
  end

  always_comb begin
    p_cur  = '0;
    r_cur  = '0;
    in_bit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) begin
        p_cur  = pot_q[i];
        r_cur  = ref_q[i];
        in_bit = spk_in_q[i];
      end
    end
  end

  lif_update_unit #(
    .W          (W),
    .IN_WEIGHT  (IN_WEIGHT),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRAC     (REFRAC),
    .RESET_VAL  (RESET_VAL),
    .RW         (RW)
  ) u_update (
    .p      (p_cur),
    .r      (r_cur),
    .in_bit (in_bit),
    .thresh (thr_q),
    .p_next (p_next),
    .r_next (r_next),
    .spike  (spike)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      spk_in_q  <= '0;
      thr_q     <= '0;
      out_spk_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (clr) begin
        out_spk_q <= '0;
      end else if (accept) begin
        spk_in_q  <= bus.in_spikes;
        thr_q     <= bus.thresh;
        out_spk_q <= '0;
      end else if (step) begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IW'(i)) begin
            out_spk_q[i] <= spike;
          end
        end
      end
    end
  end

  // Neuron state always clears to zero; RESET_VAL applies only after a spike.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        pot_q[i] <= '0;
        ref_q[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < N; i++) begin
        pot_q[i] <= '0;
        ref_q[i] <= '0;
      end
    end else if (step) begin
      for (int i = 0; i < N; i++) begin
        if (idx_q == IW'(i)) begin
          pot_q[i] <= p_next;
          ref_q[i] <= r_next;
        end
      end
    end
  end

  assign bus.out_spikes = out_spk_q;

endmodule
